// File: rtl/sd_bridge_pkg.sv
// Shared constants and types for the UART-to-SD command bridge.
// Opcodes, echo characters, parser states and the pattern reset value.
package sd_bridge_pkg;

    localparam logic [7:0] OP_WRITE   = 8'h77; // 'w'
    localparam logic [7:0] OP_READ    = 8'h72; // 'r'
    localparam logic [7:0] OP_PATTERN = 8'h70; // 'p'
    localparam logic [7:0] OP_CLEAR   = 8'h63; // 'c'

    localparam logic [7:0] ECHO_OK  = 8'h4B; // 'K'
    localparam logic [7:0] ECHO_ERR = 8'h45; // 'E'

    localparam logic [7:0] WD_RESET_PAT = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_SEED,
        ST_ISSUE,
        ST_WAIT_ACK
    } parse_state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ) ||
               (b == OP_PATTERN) || (b == OP_CLEAR);
    endfunction

endpackage

// File: rtl/sd_bridge_fifo.sv
// First-word-fall-through FIFO with flush and almost-full flag.
// Ports: clk, rst (async high), flush, push/din, pop/head,
//        empty, full, afull (free entries < BUSY_MARGIN).
// A push while full is accepted only if a pop happens the same cycle.
module sd_bridge_fifo
    import sd_bridge_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int AWIDTH      = 6,
    parameter int BUSY_MARGIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             afull
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AWIDTH:0]  wr_ptr;
    logic [AWIDTH:0]  rd_ptr;
    logic [AWIDTH:0]  count;
    logic [AWIDTH:0]  free;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra bit so count == DEPTH is distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign free  = (AWIDTH+1)'(DEPTH) - count;
    assign empty = (count == '0);
    assign full  = count[AWIDTH];
    assign afull = 32'(free) < BUSY_MARGIN;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AWIDTH-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AWIDTH+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AWIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AWIDTH-1:0]] <= din;
    end

endmodule

// File: rtl/sd_cmd_bridge.sv
// UART command parser driving an SD card driver, plus a result FIFO
// that streams read bytes back out of the UART transmitter.
// Ports: CLK/RST, RX_* (UART in), TX_* (UART out), WR_* / RD_*
//        (card requests), WD_* (write pattern), RES_* (read results),
//        BUSY (request outstanding), OVF (sticky result overflow).
// Option: define SD_BRIDGE_ECHO_EN to send 'K'/'E' status bytes.
module sd_cmd_bridge
    import sd_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int FIFO_AW     = 6,
    parameter int BUSY_MARGIN = 4,
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_STB,
    input  logic [7:0]        RX_DAT,
    output logic              RX_ACK,
    output logic              TX_STB,
    output logic [7:0]        TX_DAT,
    input  logic              TX_RDY,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [LEN_W-1:0]  WR_LENGTH,
    input  logic              WR_ACK,
    output logic              WD_STB,
    output logic [7:0]        WD_DATA,
    input  logic              WD_ACK,
    output logic              RD_STB,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic [LEN_W-1:0]  RD_LENGTH,
    input  logic              RD_ACK,
    input  logic              RES_STB,
    input  logic [7:0]        RES_DATA,
    output logic              RES_BUSY,
    output logic              BUSY,
    output logic              OVF
);

    localparam int ABYTES = ADDR_W / 8;
    localparam int LBYTES = LEN_W / 8;
    localparam int NBYTES = (ABYTES > LBYTES) ? ABYTES : LBYTES;
    localparam int BC_W   = $clog2(NBYTES) + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1) + 1;

    localparam logic [BC_W-1:0] A_LAST   = BC_W'(ABYTES - 1);
    localparam logic [BC_W-1:0] L_LAST   = BC_W'(LBYTES - 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    parse_state_t      state;
    logic              is_rd;
    logic [BC_W-1:0]   byte_cnt;
    logic [TO_W-1:0]   tmo_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [LEN_W-1:0]  len_sr;

    logic in_frame;
    logic tmo_hit;
    logic ack_hit;
    logic clr_cmd;

    logic       res_pop;
    logic       res_empty;
    logic       res_full;
    logic [7:0] res_head;
    logic       res_ready;
    logic       src_valid;
    logic [7:0] src_byte;
    logic       tx_go;
    logic       tx_d2;

    assign RX_ACK = RX_STB;
    assign WD_STB = 1'b1;

    assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                      (state == ST_SEED);
    // Abort once more than TIMEOUT_CYC byte-less cycles have elapsed.
    assign tmo_hit  = in_frame && !RX_STB && (tmo_cnt == TO_LIMIT);
    assign ack_hit  = (state == ST_WAIT_ACK) &&
                      ((WR_STB && WR_ACK) || (RD_STB && RD_ACK));
    assign clr_cmd  = RX_STB && (state == ST_IDLE) &&
                      (RX_DAT == OP_CLEAR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            is_rd     <= 1'b0;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            addr_sr   <= '0;
            len_sr    <= '0;
            WR_STB    <= 1'b0;
            WR_ADDR   <= '0;
            WR_LENGTH <= '0;
            RD_STB    <= 1'b0;
            RD_ADDR   <= '0;
            RD_LENGTH <= '0;
            BUSY      <= 1'b0;
            WD_DATA   <= WD_RESET_PAT;
        end else begin
            if (WD_ACK) WD_DATA <= WD_DATA + 8'd1;

            if (in_frame && !RX_STB) tmo_cnt <= tmo_cnt + TO_W'(1);
            else                     tmo_cnt <= '0;

            unique case (state)
                ST_IDLE: begin
                    if (RX_STB) begin
                        unique case (1'b1)
                            (RX_DAT == OP_WRITE),
                            (RX_DAT == OP_READ): begin
                                is_rd    <= (RX_DAT == OP_READ);
                                byte_cnt <= '0;
                                state    <= ST_ADDR;
                            end
                            (RX_DAT == OP_PATTERN): state <= ST_SEED;
                            default:                state <= ST_IDLE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (tmo_hit) begin
                        state <= ST_IDLE;
                    end else if (RX_STB) begin
                        addr_sr <= (addr_sr << 8) | ADDR_W'(RX_DAT);
                        if (byte_cnt == A_LAST) begin
                            byte_cnt <= '0;
                            state    <= ST_LEN;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                ST_LEN: begin
                    if (tmo_hit) begin
                        state <= ST_IDLE;
                    end else if (RX_STB) begin
                        len_sr <= (len_sr << 8) | LEN_W'(RX_DAT);
                        if (byte_cnt == L_LAST) begin
                            byte_cnt <= '0;
                            BUSY     <= 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                        end
                    end
                end
                ST_SEED: begin
                    if (tmo_hit) begin
                        state <= ST_IDLE;
                    end else if (RX_STB) begin
                        // Seed overrides a same-cycle WD_ACK increment.
                        WD_DATA <= RX_DAT;
                        state   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (is_rd) begin
                        RD_ADDR   <= addr_sr;
                        RD_LENGTH <= len_sr;
                        RD_STB    <= 1'b1;
                    end else begin
                        WR_ADDR   <= addr_sr;
                        WR_LENGTH <= len_sr;
                        WR_STB    <= 1'b1;
                    end
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack_hit) begin
                        WR_STB <= 1'b0;
                        RD_STB <= 1'b0;
                        BUSY   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sd_bridge_fifo #(
        .WIDTH      (8),
        .AWIDTH     (FIFO_AW),
        .BUSY_MARGIN(BUSY_MARGIN)
    ) u_res_fifo (
        .clk  (CLK),
        .rst  (RST),
        .flush(clr_cmd),
        .push (RES_STB),
        .din  (RES_DATA),
        .pop  (res_pop),
        .head (res_head),
        .empty(res_empty),
        .full (res_full),
        .afull(RES_BUSY)
    );

    // Don't launch a result byte in the cycle its FIFO is flushed.
    assign res_ready = !res_empty && !clr_cmd;

`ifdef SD_BRIDGE_ECHO_EN
    logic       echo_push;
    logic [7:0] echo_chr;
    logic       echo_pop;
    logic       echo_empty;
    logic [7:0] echo_head;
    logic       echo_full_unused;
    logic       echo_afull_unused;
    logic       bad_op;
    logic       drop_byte;

    assign bad_op    = RX_STB && (state == ST_IDLE) && !is_opcode(RX_DAT);
    // The ACK cycle itself reports 'K'; a byte landing then is lost silently.
    assign drop_byte = RX_STB && BUSY && !ack_hit;
    assign echo_push = ack_hit || bad_op || drop_byte || tmo_hit;
    assign echo_chr  = ack_hit ? ECHO_OK : ECHO_ERR;

    sd_bridge_fifo #(
        .WIDTH      (8),
        .AWIDTH     (2),
        .BUSY_MARGIN(1)
    ) u_echo_fifo (
        .clk  (CLK),
        .rst  (RST),
        .flush(1'b0),
        .push (echo_push),
        .din  (echo_chr),
        .pop  (echo_pop),
        .head (echo_head),
        .empty(echo_empty),
        .full (echo_full_unused),
        .afull(echo_afull_unused)
    );

    assign src_valid = !echo_empty || res_ready;
    assign src_byte  = !echo_empty ? echo_head : res_head;
    assign echo_pop  = tx_go && !echo_empty;
    assign res_pop   = tx_go && echo_empty;
`else
    assign src_valid = res_ready;
    assign src_byte  = res_head;
    assign res_pop   = tx_go;
`endif

    // TX_STB is the previous cycle's launch; tx_d2 the one before it.
    assign tx_go = src_valid && TX_RDY && !TX_STB && !tx_d2;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX_STB <= 1'b0;
            TX_DAT <= 8'h00;
            tx_d2  <= 1'b0;
        end else begin
            TX_STB <= tx_go;
            tx_d2  <= TX_STB;
            if (tx_go) TX_DAT <= src_byte;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (clr_cmd) begin
            OVF <= 1'b0;
        end else if (RES_STB && res_full && !res_pop) begin
            OVF <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_cmd_bridge.sv
// Scoreboard bench for sd_cmd_bridge: requests and TX bytes are
// queued as issued and checked by a separate negedge monitor.
`timescale 1ns/1ps
module tb_sd_cmd_bridge;
    import sd_bridge_pkg::*;

    localparam int TO = 50;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX_STB, RX_ACK, TX_STB, TX_RDY;
    logic [7:0]  RX_DAT, TX_DAT;
    logic        WR_STB, WR_ACK, WD_STB, WD_ACK, RD_STB, RD_ACK;
    logic [31:0] WR_ADDR, RD_ADDR;
    logic [7:0]  WR_LENGTH, RD_LENGTH, WD_DATA;
    logic        RES_STB, RES_BUSY, BUSY, OVF;
    logic [7:0]  RES_DATA;

    always #5 CLK = ~CLK;

    sd_cmd_bridge #(
        .ADDR_W(32), .LEN_W(8), .FIFO_AW(6),
        .BUSY_MARGIN(4), .TIMEOUT_CYC(TO)
    ) dut (
        .CLK(CLK), .RST(RST),
        .RX_STB(RX_STB), .RX_DAT(RX_DAT), .RX_ACK(RX_ACK),
        .TX_STB(TX_STB), .TX_DAT(TX_DAT), .TX_RDY(TX_RDY),
        .WR_STB(WR_STB), .WR_ADDR(WR_ADDR), .WR_LENGTH(WR_LENGTH),
        .WR_ACK(WR_ACK),
        .WD_STB(WD_STB), .WD_DATA(WD_DATA), .WD_ACK(WD_ACK),
        .RD_STB(RD_STB), .RD_ADDR(RD_ADDR), .RD_LENGTH(RD_LENGTH),
        .RD_ACK(RD_ACK),
        .RES_STB(RES_STB), .RES_DATA(RES_DATA), .RES_BUSY(RES_BUSY),
        .BUSY(BUSY), .OVF(OVF)
    );

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    req_t       exp_req[$];
    logic [7:0] exp_tx[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_req(input logic rd, input logic [31:0] a,
                             input logic [7:0] l);
        req_t e;
        if (exp_req.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL req_unexpected: got rd=%0d addr=0x%0h expected none",
                     rd, a);
        end else begin
            e = exp_req.pop_front();
            chk("req_kind", 32'(rd), 32'(e.rd));
            chk("req_addr", a, e.addr);
            chk("req_len", 32'(l), 32'(e.len));
        end
    endtask

    // Monitor: compares every TX byte and every request rise.
    initial begin
        int   cyc;
        int   last_tx;
        logic wr_q, rd_q;
        cyc = 0; last_tx = -100; wr_q = 1'b0; rd_q = 1'b0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (TX_STB) begin
                chk("tx_gap_ge3", 32'(cyc - last_tx >= 3), 32'd1);
                last_tx = cyc;
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got 0x%0h expected none",
                             TX_DAT);
                end else begin
                    chk("tx_dat", 32'(TX_DAT), 32'(exp_tx.pop_front()));
                end
            end
            if (WR_STB && !wr_q) check_req(1'b0, WR_ADDR, WR_LENGTH);
            if (RD_STB && !rd_q) check_req(1'b1, RD_ADDR, RD_LENGTH);
            wr_q = WR_STB;
            rd_q = RD_STB;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        RX_STB = 1'b1;
        RX_DAT = b;
        tick();
        RX_STB = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a,
                              input logic [7:0] l);
        send(op);
        send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
        send(l);
    endtask

    task automatic wait_stb(input bit rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (rd ? RD_STB : WR_STB) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Holds off the ACK until the strobe has been seen high n cycles.
    task automatic do_ack(input bit rd, input int n);
        bit ok;
        int hi;
        wait_stb(rd, ok);
        chk("req_seen", 32'(ok), 32'd1);
        if (!ok) return;
        chk("busy_during_req", 32'(BUSY), 32'd1);
        hi = 1;
        while (hi < n) begin
            @(negedge CLK);
            if (rd ? RD_STB : WR_STB) hi++;
            else break;
        end
        chk("stb_held_cycles", 32'(hi), 32'(n));
        if (rd) RD_ACK = 1'b1;
        else    WR_ACK = 1'b1;
`ifdef SD_BRIDGE_ECHO_EN
        exp_tx.push_back(8'h4B);
`endif
        tick();
        RD_ACK = 1'b0;
        WR_ACK = 1'b0;
        @(negedge CLK);
        chk("stb_drop", 32'(rd ? RD_STB : WR_STB), 32'd0);
        chk("busy_drop", 32'(BUSY), 32'd0);
        tick();
    endtask

    task automatic wd_pulse();
        WD_ACK = 1'b1;
        tick();
        WD_ACK = 1'b0;
    endtask

    task automatic check_wd(input logic [7:0] v);
        @(negedge CLK);
        chk("wd_data", 32'(WD_DATA), 32'(v));
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("tx_drained", 32'(exp_tx.size()), 32'd0);
    endtask

    initial begin
        bit ok;
        RX_STB = 0; RX_DAT = 0; TX_RDY = 1; WR_ACK = 0; RD_ACK = 0;
        WD_ACK = 0; RES_STB = 0; RES_DATA = 0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wr_stb", 32'(WR_STB), 32'd0);
        chk("rst_rd_stb", 32'(RD_STB), 32'd0);
        chk("rst_tx_stb", 32'(TX_STB), 32'd0);
        chk("rst_tx_dat", 32'(TX_DAT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ovf", 32'(OVF), 32'd0);
        chk("rst_wd_stb", 32'(WD_STB), 32'd1);
        chk("rst_wd_data", 32'(WD_DATA), 32'h41);
        chk("rst_res_busy", 32'(RES_BUSY), 32'd0);
        chk("rst_wr_addr", WR_ADDR, 32'd0);
        chk("rst_rd_len", 32'(RD_LENGTH), 32'd0);
        RST = 1'b0;
        tick();

        // Unknown opcode: RX_ACK mirrors RX_STB, parser stays idle.
`ifdef SD_BRIDGE_ECHO_EN
        exp_tx.push_back(8'h45);
`endif
        RX_STB = 1'b1;
        RX_DAT = 8'h78;
        #1 chk("rx_ack_hi", 32'(RX_ACK), 32'd1);
        tick();
        RX_STB = 1'b0;
        #1 chk("rx_ack_lo", 32'(RX_ACK), 32'd0);
        tick();

        // Write request acknowledged 5 cycles after the strobe rises.
        exp_req.push_back('{1'b0, 32'h0000000A, 8'h03});
        send_frame(8'h77, 32'h0000000A, 8'h03);
        do_ack(1'b0, 5);

        // Pattern seed and increment, including wrap and seed priority.
        send(8'h70); send(8'h30);
        check_wd(8'h30);
        wd_pulse(); check_wd(8'h31);
        wd_pulse(); check_wd(8'h32);
        wd_pulse(); check_wd(8'h33);
        send(8'h70); send(8'hFF);
        wd_pulse(); check_wd(8'h00);
        send(8'h70);
        WD_ACK = 1'b1;
        send(8'h55);
        WD_ACK = 1'b0;
        check_wd(8'h55);

        // Truncated read frame times out without a request.
`ifdef SD_BRIDGE_ECHO_EN
        exp_tx.push_back(8'h45);
`endif
        send(8'h72); send(8'h00); send(8'h00);
        repeat (TO + 30) tick();
        chk("tmo_state_idle", 32'(dut.state), 32'(ST_IDLE));
        send(8'h70); send(8'h77);
        check_wd(8'h77);

        // Read request acknowledged immediately.
        exp_req.push_back('{1'b1, 32'h00000100, 8'h10});
        send_frame(8'h72, 32'h00000100, 8'h10);
        do_ack(1'b1, 1);
        wait_drain();

        // Fill the result FIFO with TX stalled, overflowing on byte 65.
        TX_RDY = 1'b0;
        for (int i = 0; i < 65; i++) begin
            RES_STB = 1'b1;
            RES_DATA = 8'(i);
            @(negedge CLK);
            chk("res_busy", 32'(RES_BUSY), 32'(i >= 61));
            chk("ovf_before_full", 32'(OVF), 32'd0);
            tick();
        end
        RES_STB = 1'b0;
        @(negedge CLK);
        chk("ovf_set", 32'(OVF), 32'd1);
        chk("res_busy_full", 32'(RES_BUSY), 32'd1);
        tick();
        send(8'h63);
        @(negedge CLK);
        chk("ovf_cleared", 32'(OVF), 32'd0);
        chk("res_busy_flushed", 32'(RES_BUSY), 32'd0);
        chk("fifo_empty", 32'(dut.res_empty), 32'd1);
        tick();
        TX_RDY = 1'b1;
        repeat (20) tick();

        // Result bytes stream out in order, spaced >= 3 cycles.
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        RES_STB = 1'b1;
        RES_DATA = 8'h11; tick();
        RES_DATA = 8'h22; tick();
        RES_DATA = 8'h33; tick();
        RES_STB = 1'b0;
        wait_drain();

        // Reset while a write request is pending.
        exp_req.push_back('{1'b0, 32'h12345678, 8'h20});
        send_frame(8'h77, 32'h12345678, 8'h20);
        wait_stb(1'b0, ok);
        chk("req_before_rst", 32'(ok), 32'd1);
        RST = 1'b1;
        tick();
        chk("rst_mid_wr_stb", 32'(WR_STB), 32'd0);
        chk("rst_mid_busy", 32'(BUSY), 32'd0);
        chk("rst_mid_wr_addr", WR_ADDR, 32'd0);
        RST = 1'b0;
        repeat (30) tick();
        chk("rst_mid_idle", 32'(dut.state), 32'(ST_IDLE));
        exp_req.push_back('{1'b0, 32'hDEADBEEF, 8'h01});
        send_frame(8'h77, 32'hDEADBEEF, 8'h01);
        do_ack(1'b0, 2);
        wait_drain();

        repeat (5) tick();
        chk("req_queue_empty", 32'(exp_req.size()), 32'd0);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
